// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and helpers for the direct-mapped write-through data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

    // Number of index bits selecting one of SETS one-word lines
    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left above the index and the two byte-offset bits
    function automatic int tag_width(input int address_width, input int sets);
        return address_width - $clog2(sets) - 2;
    endfunction

    // Replace the byte lanes selected by be with the matching lanes of new_word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/tag/data storage with combinational lookup and one write port
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int SETS          = 8,
    localparam int IW            = index_width(SETS),
    localparam int TW            = tag_width(ADDRESS_WIDTH, SETS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] lookup_index,
    input  logic [TW-1:0] lookup_tag,
    output logic          lookup_hit,
    output logic [31:0]   lookup_word,
    input  logic          wr_en,
    input  logic          wr_fill,
    input  logic [IW-1:0] wr_index,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be
);

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS];

    assign lookup_hit  = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
    assign lookup_word = data_q[lookup_index];

    // Valid bits: cleared by reset, set only by a completed line fill
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en && wr_fill) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data: fills overwrite the line, stores merge bytes only into a resident matching line
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_fill) begin
                tag_q[wr_index]  <= wr_tag;
                data_q[wr_index] <= wr_data;
            end else if (valid_q[wr_index] && (tag_q[wr_index] == wr_tag)) begin
                data_q[wr_index] <= merge_bytes(data_q[wr_index], wr_data, wr_be);
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache (optional DCACHE_STATS_EN hit/miss counters)
module data_cache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SETS          = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic                     CpuRead,
    input  logic                     WE0,
    input  logic                     WE1,
    input  logic                     WE2,
    input  logic                     WE3,
    input  logic [DATA_WIDTH-1:0]    WD,
    output logic [DATA_WIDTH-1:0]    RD,
    output logic                     Stall,
    output logic                     MemReq,
    output logic                     MemWrite,
    output logic [ADDRESS_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0]    MemWD,
    output logic [3:0]               MemBE,
    input  logic                     MemAck,
    input  logic [DATA_WIDTH-1:0]    MemRD
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              HitCount,
    output logic [31:0]              MissCount
`endif
);

    localparam int IW = index_width(SETS);
    localparam int TW = tag_width(ADDRESS_WIDTH, SETS);

    dcache_state_t            state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wd_q;
    logic [3:0]               be_q;

    logic [3:0]               we_vec;
    logic                     store_req;
    logic                     lookup_hit;
    logic [31:0]              lookup_word;
    logic                     wr_en;
    logic                     wr_fill;
    logic [31:0]              wr_data;
    logic [ADDRESS_WIDTH-1:0] aligned_addr;
    logic                     unused_addr_bits;

    assign we_vec           = {WE3, WE2, WE1, WE0};
    assign store_req        = |we_vec;
    assign aligned_addr     = {A[ADDRESS_WIDTH-1:2], 2'b00};
    assign unused_addr_bits = ^A[1:0];

    dcache_array #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .SETS          (SETS)
    ) u_array (
        .clk          (CLK),
        .rst          (RST),
        .lookup_index (A[IW+1:2]),
        .lookup_tag   (A[ADDRESS_WIDTH-1:IW+2]),
        .lookup_hit   (lookup_hit),
        .lookup_word  (lookup_word),
        .wr_en        (wr_en),
        .wr_fill      (wr_fill),
        .wr_index     (addr_q[IW+1:2]),
        .wr_tag       (addr_q[ADDRESS_WIDTH-1:IW+2]),
        .wr_data      (wr_data),
        .wr_be        (be_q)
    );

    assign MemReq   = (state_q != IDLE);
    assign MemWrite = (state_q == WRITE);
    assign MemAddr  = addr_q;
    assign MemWD    = wd_q;
    assign MemBE    = be_q;

    // Next state, stall, load data and array write strobes; stores win over loads in IDLE
    always_comb begin
        state_d = state_q;
        Stall   = 1'b0;
        RD      = '0;
        wr_en   = 1'b0;
        wr_fill = 1'b0;
        wr_data = wd_q;
        case (state_q)
            IDLE: begin
                if (store_req) begin
                    Stall   = 1'b1;
                    state_d = WRITE;
                end else if (CpuRead) begin
                    if (lookup_hit) begin
                        RD = lookup_word;
                    end else begin
                        Stall   = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (MemAck) begin
                    RD      = MemRD;
                    wr_en   = 1'b1;
                    wr_fill = 1'b1;
                    wr_data = MemRD;
                    state_d = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            WRITE: begin
                if (MemAck) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A reset abandons any in-flight transaction, so nothing may be allocated or merged
        if (RST) begin
            wr_en = 1'b0;
        end
    end

    // State register and memory-side request registers, captured on leaving IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == WRITE) begin
                addr_q <= aligned_addr;
                wd_q   <= WD;
                be_q   <= we_vec;
            end else if (state_q == IDLE && state_d == FILL) begin
                addr_q <= aligned_addr;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Saturating load hit/miss counters; stores never count
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (state_q == IDLE && !store_req && CpuRead && lookup_hit && hit_count_q != 32'hFFFF_FFFF) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (state_q == IDLE && state_d == FILL && miss_count_q != 32'hFFFF_FFFF) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign HitCount  = hit_count_q;
    assign MissCount = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed vector bench for data_cache
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] A = '0;
    logic        CpuRead = 1'b0;
    logic        WE0 = 1'b0, WE1 = 1'b0, WE2 = 1'b0, WE3 = 1'b0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        Stall;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic [3:0]  MemBE;
    logic        MemAck = 1'b0;
    logic [31:0] MemRD = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0] HitCount;
    logic [31:0] MissCount;
`endif

    int tests = 0;
    int fails = 0;

    data_cache dut (
        .CLK      (CLK),
        .RST      (RST),
        .A        (A),
        .CpuRead  (CpuRead),
        .WE0      (WE0),
        .WE1      (WE1),
        .WE2      (WE2),
        .WE3      (WE3),
        .WD       (WD),
        .RD       (RD),
        .Stall    (Stall),
        .MemReq   (MemReq),
        .MemWrite (MemWrite),
        .MemAddr  (MemAddr),
        .MemWD    (MemWD),
        .MemBE    (MemBE),
        .MemAck   (MemAck),
        .MemRD    (MemRD)
`ifdef DCACHE_STATS_EN
        ,
        .HitCount  (HitCount),
        .MissCount (MissCount)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        rd_en;
        logic [3:0]  we;
        logic [31:0] wd;
        int          delay;
        logic [31:0] mem_rd;
        int          exp_stall;
        logic [31:0] exp_rd;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic        exp_write;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [31:0] addr, input logic rd_en, input logic [3:0] we,
                                input logic [31:0] wd, input int delay, input logic [31:0] mem_rd,
                                input int exp_stall, input logic [31:0] exp_rd, input logic exp_mem,
                                input logic [31:0] exp_addr, input logic exp_write, input logic [3:0] exp_be);
        vec_t v;
        v.addr = addr; v.rd_en = rd_en; v.we = we; v.wd = wd; v.delay = delay; v.mem_rd = mem_rd;
        v.exp_stall = exp_stall; v.exp_rd = exp_rd; v.exp_mem = exp_mem; v.exp_addr = exp_addr;
        v.exp_write = exp_write; v.exp_be = exp_be;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts just after a rising edge; returns just after the rising edge that ends the access
    task automatic run_op(input string name, input vec_t v);
        int          stall_n = 0;
        int          req_cyc = 0;
        logic        done = 1'b0;
        logic        mem_seen = 1'b0;
        logic [31:0] got_rd = '0;
        logic [31:0] got_addr = '0;
        logic [31:0] got_wd = '0;
        logic [3:0]  got_be = '0;
        logic        got_write = 1'b0;
        A = v.addr; CpuRead = v.rd_en; WD = v.wd;
        {WE3, WE2, WE1, WE0} = v.we;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (MemReq) begin
                if (req_cyc == v.delay) begin
                    MemAck = 1'b1; MemRD = v.mem_rd; mem_seen = 1'b1;
                    got_addr = MemAddr; got_wd = MemWD; got_be = MemBE; got_write = MemWrite;
                end
                req_cyc++;
            end
            #1;
            if (Stall) stall_n++;
            else begin
                done = 1'b1;
                got_rd = RD;
            end
            @(posedge CLK);
            #1;
            MemAck = 1'b0;
        end
        CpuRead = 1'b0;
        {WE3, WE2, WE1, WE0} = 4'b0000;
        check({name, " finished"}, {31'd0, done}, 32'd1);
        check({name, " stall cycles"}, stall_n, v.exp_stall);
        check({name, " RD"}, got_rd, v.exp_rd);
        check({name, " mem txn"}, {31'd0, mem_seen}, {31'd0, v.exp_mem});
        if (v.exp_mem) begin
            check({name, " MemAddr"}, got_addr, v.exp_addr);
            check({name, " MemWrite"}, {31'd0, got_write}, {31'd0, v.exp_write});
            if (v.exp_write) begin
                check({name, " MemBE"}, {28'd0, got_be}, {28'd0, v.exp_be});
                check({name, " MemWD"}, got_wd, v.wd);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'h00, 0, 4'h0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 4'h0);
        vecs[1]  = mk(32'h40, 1, 4'h0, 32'h0,         2, 32'hDEADBEEF,  3, 32'hDEADBEEF,  1, 32'h40, 0, 4'h0);
        vecs[2]  = mk(32'h43, 1, 4'h0, 32'h0,         0, 32'h0,         0, 32'hDEADBEEF,  0, 32'h0,  0, 4'h0);
        vecs[3]  = mk(32'h60, 1, 4'h0, 32'h0,         0, 32'h11112222,  1, 32'h11112222,  1, 32'h60, 0, 4'h0);
        vecs[4]  = mk(32'h40, 1, 4'h0, 32'h0,         1, 32'hDEADBEEF,  2, 32'hDEADBEEF,  1, 32'h40, 0, 4'h0);
        vecs[5]  = mk(32'h40, 0, 4'h1, 32'h000000AA,  1, 32'h0,         2, 32'h0,         1, 32'h40, 1, 4'h1);
        vecs[6]  = mk(32'h40, 1, 4'h0, 32'h0,         0, 32'h0,         0, 32'hDEADBEAA,  0, 32'h0,  0, 4'h0);
        vecs[7]  = mk(32'h80, 0, 4'hF, 32'h12345678,  0, 32'h0,         1, 32'h0,         1, 32'h80, 1, 4'hF);
        vecs[8]  = mk(32'h80, 1, 4'h0, 32'h0,         0, 32'h12345678,  1, 32'h12345678,  1, 32'h80, 0, 4'h0);
        vecs[9]  = mk(32'h86, 1, 4'hC, 32'hAABB0000,  3, 32'h0,         4, 32'h0,         1, 32'h84, 1, 4'hC);
        vecs[10] = mk(32'h84, 1, 4'h0, 32'h0,         0, 32'hAABB0000,  1, 32'hAABB0000,  1, 32'h84, 0, 4'h0);
        vecs[11] = mk(32'h84, 0, 4'h2, 32'h0000CC00,  0, 32'h0,         1, 32'h0,         1, 32'h84, 1, 4'h2);
        vecs[12] = mk(32'h84, 1, 4'h0, 32'h0,         0, 32'h0,         0, 32'hAABBCC00,  0, 32'h0,  0, 4'h0);
        vecs[13] = mk(32'h40, 1, 4'h0, 32'h0,         0, 32'hDEADBEAA,  1, 32'hDEADBEAA,  1, 32'h40, 0, 4'h0);

        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        @(negedge CLK);
        check("reset MemReq",   {31'd0, MemReq},   32'd0);
        check("reset MemWrite", {31'd0, MemWrite}, 32'd0);
        check("reset MemAddr",  MemAddr,           32'd0);
        check("reset MemWD",    MemWD,             32'd0);
        check("reset MemBE",    {28'd0, MemBE},    32'd0);
        check("reset Stall",    {31'd0, Stall},    32'd0);
        check("reset RD",       RD,                32'd0);
        @(posedge CLK);
        #1;

        MemAck = 1'b1; MemRD = 32'hFFFF_FFFF;
        @(negedge CLK);
        check("stray ack RD",    RD,                32'd0);
        check("stray ack Stall", {31'd0, Stall},    32'd0);
        @(posedge CLK);
        #1;
        MemAck = 1'b0;
        @(negedge CLK);
        check("stray ack MemReq", {31'd0, MemReq},  32'd0);
        @(posedge CLK);
        #1;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        A = 32'hC0; CpuRead = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("fill before reset MemReq", {31'd0, MemReq}, 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b1; CpuRead = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("reset in fill MemReq", {31'd0, MemReq}, 32'd0);
        check("reset in fill Stall",  {31'd0, Stall},  32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        run_op("after reset load C0", mk(32'hC0, 1, 4'h0, 32'h0, 0, 32'h55AA55AA, 1, 32'h55AA55AA, 1, 32'hC0, 0, 4'h0));
        for (int i = 0; i < 3; i++) begin
            run_op($sformatf("hit C0 %0d", i), mk(32'hC0, 1, 4'h0, 32'h0, 0, 32'h0, 0, 32'h55AA55AA, 0, 32'h0, 0, 4'h0));
        end
        run_op("conflict E0", mk(32'hE0, 1, 4'h0, 32'h0, 0, 32'h0BADF00D, 1, 32'h0BADF00D, 1, 32'hE0, 0, 4'h0));
`ifdef DCACHE_STATS_EN
        @(negedge CLK);
        check("HitCount",  HitCount,  32'd3);
        check("MissCount", MissCount, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the core's load/store path and the data memory. It consumes the ALU address, store data and per-byte write enables produced by the core's WE decoder, and returns load data to the load decoder. Hits complete in the same cycle. Misses and all stores run a request/acknowledge transaction on the memory side and stall the core until that transaction completes.

## Interface
Parameters:
- DATA_WIDTH, 32, word width. The block supports 32 only, i.e. 4 byte lanes.
- ADDRESS_WIDTH, 32, CPU byte-address width.
- SETS, 8, number of one-word lines. Must be a power of 2 and at least 2.

Ports:
- CLK, in, 1: clock. All state updates on the rising edge.
- RST, in, 1: synchronous, active-high reset.
- A, in, ADDRESS_WIDTH: byte address from the ALU result.
- CpuRead, in, 1: load request.
- WE0..WE3, in, 1 each: byte-lane write enables from the WE decoder. A store is in progress when any of them is high.
- WD, in, DATA_WIDTH: store data, already lane-aligned.
- RD, out, DATA_WIDTH: load word returned to the load decoder.
- Stall, out, 1: the core must hold PC and its inputs while this is high.
- MemReq, out, 1: memory transaction valid.
- MemWrite, out, 1: 1 = store, 0 = line fill.
- MemAddr, out, ADDRESS_WIDTH: word-aligned address, bits [1:0] = 0.
- MemWD, out, DATA_WIDTH: store data.
- MemBE, out, 4: byte enables.
- MemAck, in, 1: one-cycle acknowledge. MemRD is valid during this cycle.
- MemRD, in, DATA_WIDTH: fill data.

## Operation
- Address split:
  - index = A[log2(SETS)+1:2]
  - tag = A[ADDRESS_WIDTH-1:log2(SETS)+2]
  - A[1:0] is ignored.
- Per-set storage: valid bit, tag, data word.
- Hit = CpuRead && valid[index] && tag match.
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - Read hit: RD = stored word, Stall = 0, no memory activity.
  - Read miss: Stall = 1. Register the aligned address, go to FILL.
  - Store (any WEn): Stall = 1. Register the address, WD and MemBE = {WE3,WE2,WE1,WE0}, go to WRITE.
  - If a store and CpuRead are both asserted, the store has priority.
  - No request: Stall = 0.
- FILL:
  - MemReq = 1, MemWrite = 0, held until MemAck.
  - In the MemAck cycle: RD = MemRD, Stall = 0. Write tag and data, set the valid bit, go to IDLE.
- WRITE:
  - MemReq = 1, MemWrite = 1, held until MemAck.
  - In the MemAck cycle: Stall = 0. If the line is valid with a matching tag, merge the enabled bytes of WD into it (write-through update). A miss does not allocate. Go to IDLE.
- MemAddr, MemWD and MemBE are registered and stable for the whole transaction.
- MemAck outside FILL/WRITE is ignored.
- Reset values:
  - State IDLE, all valid bits 0.
  - MemReq 0, MemWrite 0, MemAddr 0, MemWD 0, MemBE 0.
  - Stall 0 unless a request is presented. RD 0 when there is no hit.
- Reset during FILL/WRITE: the transaction is abandoned and MemReq is 0 from the next cycle. The fill does not allocate. The memory side must tolerate a dropped request.

## Timing
- Read hit: 0 cycles of stall, RD combinational from A.
- Read miss: the core stalls N+1 cycles when MemAck arrives N cycles after MemReq first rises (N ≥ 0). This is one IDLE decision cycle plus the wait; the core advances on the MemAck cycle.
- Store: same N+1 stall as a read miss, whether it hits or misses.
- Back-to-back: the next request is evaluated in the IDLE cycle immediately after MemAck, with no dead cycle.
- A load that follows a store to the same address hits only if the line was already resident before the store. Otherwise it fills from memory, which already holds the stored data.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds output ports HitCount and MissCount, each 32 bits and reset to 0.
  - HitCount increments on each IDLE read hit. MissCount increments on each IDLE→FILL transition.
  - Both saturate at 0xFFFFFFFF.
  - Stores are not counted.
- DCACHE_STATS_EN undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

## Structure
- Package dcache_pkg:
  - state enum (IDLE, FILL, WRITE)
  - function computing index/tag widths from SETS and ADDRESS_WIDTH
  - byte-lane merge function
- Sub-module dcache_array:
  - valid/tag/data storage
  - combinational lookup (hit, word)
  - single synchronous write port: fill or byte-masked update
  - valid clear on RST
- data_cache keeps the FSM, the memory-side registers and the optional counters.

## Test plan
- Reset, then load 0x00000040 with memory word 0xDEADBEEF and MemAck after 2 cycles: Stall high for 3 cycles, RD = 0xDEADBEEF in the ack cycle. A repeat load of 0x40 gives Stall 0 and the same RD.
- Conflict: load 0x40, then load 0x60 (same index, SETS=8). The second load misses and refills. Reloading 0x40 misses again.
- Resident line 0x40 = 0xDEADBEEF; store WD = 0x000000AA with WE0 only: MemBE = 0001, MemAddr = 0x40. The next load of 0x40 hits with RD = 0xDEADBEAA.
- Store to non-resident 0x80: memory write occurs, valid[0] is not set, and the following load of 0x80 misses.
- RST asserted during FILL with MemAck pending: MemReq = 0 the next cycle, state IDLE, and a load of the same address misses.
- With DCACHE_STATS_EN: 3 hits and 2 misses give HitCount = 3 and MissCount = 2. With the counter forced to 0xFFFFFFFF, a further hit leaves it at 0xFFFFFFFF.
